// File: rtl/dma_mc.sv
// dma_mc: multi-channel disk-to-memory DMA engine.
// NCH channel register sets share one slave register port; pending channels
// are granted round-robin onto a single disk read port and a single memory
// write master. Each finished channel raises a maskable interrupt status bit.
//
// Handshakes: the slave port acks every access exactly one cycle after s_cyc
// is sampled high (read data valid in that ack cycle). On the disk side a
// word moves when d_init and d_ready are both high at a clock edge; on the
// memory side a word moves when m_cyc and m_ack are both high at a clock edge.
// d_init and m_cyc are held stable, with stable address/data, until accepted.
module dma_mc #(
  parameter int NCH = 2,
  parameter int DAW = 10,
  parameter int SZW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           s_cyc,
  input  logic           s_we,
  input  logic [3:0]     s_strb,
  input  logic [31:0]    s_addr,
  input  logic [31:0]    s_data_i,
  output logic           s_ack,
  output logic [31:0]    s_data_o,
  output logic           m_cyc,
  output logic           m_we,
  output logic [3:0]     m_strb,
  output logic [31:0]    m_addr,
  output logic [31:0]    m_data_o,
  input  logic           m_ack,
  input  logic [31:0]    m_data_i,
  output logic           d_init,
  output logic [DAW-1:0] d_addr,
  input  logic           d_ready,
  input  logic [31:0]    d_data_in,
  output logic           d_done,
  input  logic           int_clear,
  output logic           interrupt,
  output logic [2:0]     dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARB  = 3'd1;
  localparam logic [2:0] S_DREQ = 3'd2;
  localparam logic [2:0] S_MWR  = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;
  localparam logic [2:0] SEL_GLOBAL = 3'd7;

  logic [2:0]     state;
  logic [DAW-1:0] disk_addr [NCH];
  logic [29:0]    mem_addr  [NCH];   // word address; byte bits [1:0] are always 0
  logic [SZW-1:0] size      [NCH];
  logic [NCH-1:0] pending, active, done, int_status, int_enable;
  logic [1:0]     rr_ptr, cur;
  logic [DAW-1:0] wk_disk;
  logic [29:0]    wk_mem;
  logic [SZW-1:0] wk_cnt;
  logic [31:0]    wk_data;

  logic           acc, wr_en;
  logic [2:0]     sel;
  logic [1:0]     reg_sel;
  logic           grant_found;
  logic [1:0]     grant_idx;
  logic [DAW-1:0] grant_disk;
  logic [29:0]    grant_mem;
  logic [SZW-1:0] grant_size;
  logic [NCH-1:0] fin_set, status_clr;
  logic [31:0]    rd_data;
  logic           unused_inputs;

  assign acc     = s_cyc & ~s_ack;
  assign wr_en   = acc & s_we;
  assign sel     = s_addr[6:4];
  assign reg_sel = s_addr[3:2];
  assign unused_inputs = ^{s_strb, m_data_i, s_addr[31:7], s_addr[1:0], s_data_i};

  // Round-robin pick: first pending channel after the last granted one.
  // Scanning offsets from far to near lets the nearest candidate win.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    for (int i = NCH; i >= 1; i--) begin
      for (int j = 0; j < NCH; j++) begin
        if (pending[j] && (j == (int'(rr_ptr) + i) % NCH)) begin
          grant_found = 1'b1;
          grant_idx   = 2'(j);
        end
      end
    end
  end

  // Register set of the granted channel, loaded into the working copies in ARB.
  always_comb begin
    grant_disk = '0;
    grant_mem  = '0;
    grant_size = '0;
    for (int j = 0; j < NCH; j++) begin
      if (grant_idx == 2'(j)) begin
        grant_disk = disk_addr[j];
        grant_mem  = mem_addr[j];
        grant_size = size[j];
      end
    end
  end

  // Interrupt status set/clear terms; FIN set wins over W1C and int_clear.
  always_comb begin
    fin_set = '0;
    for (int j = 0; j < NCH; j++) begin
      fin_set[j] = (state == S_FIN) && (cur == 2'(j));
    end
    status_clr = {NCH{int_clear}};
    if (wr_en && sel == SEL_GLOBAL && reg_sel == 2'd0) begin
      status_clr = status_clr | s_data_i[NCH-1:0];
    end
  end

  // Read mux; unmapped channel selects read as zero.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NCH; c++) begin
      if (sel == 3'(c)) begin
        case (reg_sel)
          2'd0: rd_data = 32'(disk_addr[c]);
          2'd1: rd_data = {mem_addr[c], 2'b00};
          2'd2: rd_data = 32'(size[c]);
          2'd3: rd_data = {30'd0, done[c], pending[c] | active[c]};
        endcase
      end
    end
    if (sel == SEL_GLOBAL) begin
      if (reg_sel == 2'd0) rd_data = 32'(int_status);
      if (reg_sel == 2'd1) rd_data = 32'(int_enable);
    end
  end

  // Slave port: single-cycle ack with registered read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_ack    <= 1'b0;
      s_data_o <= '0;
    end else begin
      s_ack    <= acc;
      s_data_o <= (acc && !s_we) ? rd_data : '0;
    end
  end

  // Channel register sets: CPU writes (blocked while busy), grant and write-back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        disk_addr[c] <= '0;
        mem_addr[c]  <= '0;
        size[c]      <= '0;
      end
      pending <= '0;
      active  <= '0;
      done    <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (wr_en && sel == 3'(c) && !(pending[c] || active[c])) begin
          case (reg_sel)
            2'd0: disk_addr[c] <= s_data_i[DAW-1:0];
            2'd1: mem_addr[c]  <= s_data_i[31:2];
            2'd2: size[c]      <= s_data_i[SZW-1:0];
            2'd3: if (s_data_i[0]) begin
                    pending[c] <= 1'b1;
                    done[c]    <= 1'b0;
                  end
          endcase
        end
        if (state == S_ARB && grant_found && grant_idx == 2'(c)) begin
          pending[c] <= 1'b0;
          active[c]  <= 1'b1;
        end
        if (state == S_FIN && cur == 2'(c)) begin
          active[c]    <= 1'b0;
          done[c]      <= 1'b1;
          disk_addr[c] <= wk_disk;
          mem_addr[c]  <= wk_mem;
        end
      end
    end
  end

  // Global interrupt registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      int_status <= '0;
      int_enable <= '0;
    end else begin
      int_status <= (int_status & ~status_clr) | fin_set;
      if (wr_en && sel == SEL_GLOBAL && reg_sel == 2'd1) begin
        int_enable <= s_data_i[NCH-1:0];
      end
    end
  end

  // Transfer engine: one granted channel runs to completion, word by word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      rr_ptr  <= 2'd0;
      cur     <= 2'd0;
      wk_disk <= '0;
      wk_mem  <= '0;
      wk_cnt  <= '0;
      wk_data <= '0;
      d_done  <= 1'b0;
    end else begin
      d_done <= 1'b0;
      case (state)
        S_IDLE: if (|pending) state <= S_ARB;
        S_ARB: begin
          if (grant_found) begin
            cur     <= grant_idx;
            rr_ptr  <= grant_idx;
            wk_disk <= grant_disk;
            wk_mem  <= grant_mem;
            wk_cnt  <= grant_size;
            state   <= (grant_size == '0) ? S_FIN : S_DREQ;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DREQ: if (d_ready) begin
          wk_data <= d_data_in;
          state   <= S_MWR;
        end
        S_MWR: if (m_ack) state <= S_NEXT;
        S_NEXT: begin
          wk_disk <= wk_disk + DAW'(1);
          wk_mem  <= wk_mem + 30'd1;
          wk_cnt  <= wk_cnt - SZW'(1);
          state   <= (wk_cnt == SZW'(1)) ? S_FIN : S_DREQ;
        end
        S_FIN: begin
          d_done <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign d_init    = (state == S_DREQ);
  assign d_addr    = wk_disk;
  assign m_cyc     = (state == S_MWR);
  assign m_we      = m_cyc;
  assign m_strb    = m_cyc ? 4'hF : 4'h0;
  assign m_addr    = {wk_mem, 2'b00};
  assign m_data_o  = wk_data;
  assign interrupt = |(int_status & int_enable);
  assign dbg_state = state;

endmodule

// File: tb/tb_dma_mc.sv
// tb_dma_mc: directed bench for dma_mc with a disk responder, a memory
// responder and a negedge monitor that checks bus traffic and register reads
// against expected queues filled by the stimulus.
module tb_dma_mc;
  localparam int NCH = 3;
  localparam int DAW = 10;
  localparam int SZW = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           s_cyc, s_we, s_ack;
  logic [3:0]     s_strb;
  logic [31:0]    s_addr, s_data_i, s_data_o;
  logic           m_cyc, m_we, m_ack;
  logic [3:0]     m_strb;
  logic [31:0]    m_addr, m_data_o, m_data_i;
  logic           d_init, d_ready, d_done, int_clear, interrupt;
  logic [DAW-1:0] d_addr;
  logic [31:0]    d_data_in;
  logic [2:0]     dbg_state;

  dma_mc #(.NCH(NCH), .DAW(DAW), .SZW(SZW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_cyc(s_cyc), .s_we(s_we), .s_strb(s_strb), .s_addr(s_addr),
    .s_data_i(s_data_i), .s_ack(s_ack), .s_data_o(s_data_o),
    .m_cyc(m_cyc), .m_we(m_we), .m_strb(m_strb), .m_addr(m_addr),
    .m_data_o(m_data_o), .m_ack(m_ack), .m_data_i(m_data_i),
    .d_init(d_init), .d_addr(d_addr), .d_ready(d_ready), .d_data_in(d_data_in),
    .d_done(d_done), .int_clear(int_clear), .interrupt(interrupt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [DAW-1:0] exp_d_q[$];
  logic [63:0]    exp_m_q[$];
  logic [31:0]    exp_r_q[$];
  int checks = 0;
  int errors = 0;
  int d_delay = 0, m_delay = 0, dcnt = 0, mcnt = 0;
  int done_cnt = 0, exp_done = 0, d_rise_cyc = 0, ack_cyc = 0;
  logic rd_flag = 1'b0;

  function automatic logic [31:0] disk_word(input logic [DAW-1:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- bus responders ----------------
  initial begin
    d_ready = 1'b0; d_data_in = '0; m_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (d_init && !d_ready) begin
        if (dcnt >= d_delay) begin
          d_ready = 1'b1; d_data_in = disk_word(d_addr);
        end else dcnt++;
      end else begin
        d_ready = 1'b0; dcnt = 0;
      end
      if (m_cyc && !m_ack) begin
        if (mcnt >= m_delay) m_ack = 1'b1;
        else mcnt++;
      end else begin
        m_ack = 1'b0; mcnt = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic           prev_d_init = 1'b0, prev_m_cyc = 1'b0, prev_s_ack = 1'b0;
  logic [DAW-1:0] prev_d_addr = '0;
  logic [31:0]    prev_m_addr = '0, prev_m_data = '0;
  int d_run = 0, m_run = 0;

  always @(negedge clk) begin
    if (d_init === 1'b1 || m_cyc === 1'b1) chk("bus_exclusive", d_init & m_cyc, 0);
    d_run = (d_init === 1'b1) ? d_run + 1 : 0;
    m_run = (m_cyc === 1'b1) ? m_run + 1 : 0;
    if (d_init === 1'b1 && !prev_d_init) d_rise_cyc = cyc;
    if (d_init === 1'b1 && prev_d_init) chk("d_addr_stable", d_addr, prev_d_addr);
    if (m_cyc === 1'b1 && prev_m_cyc) chk("m_stable", {m_addr, m_data_o}, {prev_m_addr, prev_m_data});
    if (d_init === 1'b1 && d_ready) begin
      chk("d_hold_len", d_run, d_delay + 1);
      if (exp_d_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL d_unexpected: disk read of 0x%0h with none expected", d_addr);
      end else chk("d_addr", d_addr, exp_d_q.pop_front());
    end
    if (m_cyc === 1'b1 && m_ack) begin
      chk("m_strobes", {m_we, m_strb}, 5'h1F);
      chk("m_hold_len", m_run, m_delay + 1);
      if (exp_m_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL m_unexpected: write 0x%0h to 0x%0h with none expected", m_data_o, m_addr);
      end else chk("m_addr_data", {m_addr, m_data_o}, exp_m_q.pop_front());
    end
    if (s_ack === 1'b1) chk("s_ack_single", prev_s_ack, 0);
    if (s_ack === 1'b1 && rd_flag) begin
      if (exp_r_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: read data 0x%0h with none expected", s_data_o);
      end else chk($sformatf("rd@%0h", s_addr), s_data_o, exp_r_q.pop_front());
    end
    if (d_done === 1'b1) done_cnt++;
    prev_d_init = (d_init === 1'b1);
    prev_m_cyc  = (m_cyc === 1'b1);
    prev_s_ack  = (s_ack === 1'b1);
    prev_d_addr = d_addr;
    prev_m_addr = m_addr;
    prev_m_data = m_data_o;
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] data);
    int n;
    n = 0;
    s_cyc = 1'b1; s_we = we; s_addr = addr; s_data_i = data;
    do begin @(posedge clk); #1; n++; end while (!s_ack && n < 8);
    chk("s_ack_latency", s_ack ? n : 99, 1);
    ack_cyc = cyc;
    s_cyc = 1'b0; s_we = 1'b0;
    @(posedge clk); #1;
    rd_flag = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus(1'b1, addr, data);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    exp_r_q.push_back(exp);
    rd_flag = 1'b1;
    bus(1'b0, addr, 32'h0);
  endtask

  function automatic logic [31:0] ra(input int c, input int r);
    return 32'((c << 4) | (r << 2));
  endfunction

  task automatic cfg(input int c, input logic [31:0] disk, input logic [31:0] mem, input logic [31:0] sz);
    wr(ra(c, 0), disk); wr(ra(c, 1), mem); wr(ra(c, 2), sz);
  endtask

  task automatic start(input int c);
    wr(ra(c, 3), 32'h1);
  endtask

  task automatic expect_xfer(input int disk, input logic [31:0] mem, input int n);
    logic [DAW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = DAW'(disk + i);
      exp_d_q.push_back(a);
      exp_m_q.push_back({mem + 32'(4 * i), disk_word(a)});
    end
  endtask

  task automatic wait_done(input int n_more);
    int n;
    n = 0;
    exp_done += n_more;
    while (done_cnt < exp_done && n < 2000) begin @(posedge clk); #1; n++; end
    idle(3);
    chk("done_pulses", done_cnt, exp_done);
  endtask

  // ---------------- stimulus ----------------
  int t_ack;
  initial begin
    rst_n = 1'b0; s_cyc = 1'b0; s_we = 1'b0; s_strb = 4'hF; s_addr = '0;
    s_data_i = '0; m_data_i = 32'hDEAD_BEEF; int_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    chk("rst_outputs", {d_init, m_cyc, m_we, m_strb, s_ack, d_done, interrupt, dbg_state, d_addr, m_addr}, 0);
    rd(ra(0, 3), 0); rd(ra(0, 0), 0); rd(ra(2, 2), 0); rd(32'h70, 0); rd(32'h74, 0);

    // single word, start latency, interrupt masking
    cfg(0, 5, 32'h100, 1);
    expect_xfer(5, 32'h100, 1);
    start(0);
    t_ack = ack_cyc;
    wait_done(1);
    chk("start_to_d_init", d_rise_cyc - t_ack, 2);
    rd(ra(0, 3), 2); rd(32'h70, 1);
    chk("irq_masked", interrupt, 0);
    wr(32'h74, 1);
    chk("irq_enabled", interrupt, 1);
    wr(32'h70, 1);
    chk("irq_w1c", interrupt, 0);
    rd(32'h70, 0);

    // multi-word with disk address wrap; MEM_ADDR low bits read as 0
    cfg(0, 1022, 32'h203, 3);
    rd(ra(0, 1), 32'h200);
    expect_xfer(1022, 32'h200, 3);
    start(0);
    wait_done(1);
    rd(ra(0, 0), 1); rd(ra(0, 1), 32'h20C); rd(ra(0, 2), 3); rd(ra(0, 3), 2);
    chk("irq_after_xfer", interrupt, 1);
    wr(32'h70, 1);

    // back-pressure on both ports
    d_delay = 4; m_delay = 3;
    cfg(1, 32'h40, 32'h300, 2);
    expect_xfer(32'h40, 32'h300, 2);
    start(1);
    wait_done(1);
    d_delay = 0; m_delay = 0;
    rd(ra(1, 0), 32'h42); rd(ra(1, 1), 32'h308);

    // round robin: ch0 runs, ch2 and ch1 queue up behind it
    m_delay = 8;
    cfg(0, 32'h10, 32'h400, 1); cfg(1, 32'h20, 32'h500, 1); cfg(2, 32'h30, 32'h600, 1);
    expect_xfer(32'h10, 32'h400, 1);
    expect_xfer(32'h20, 32'h500, 1);
    expect_xfer(32'h30, 32'h600, 1);
    start(0); start(2); start(1);
    wait_done(3);
    // ch1 runs, ch0 and ch2 queue: pointer at 1 favours ch2 over ch0
    expect_xfer(32'h21, 32'h504, 1);
    expect_xfer(32'h31, 32'h604, 1);
    expect_xfer(32'h11, 32'h404, 1);
    start(1); start(0); start(2);
    wait_done(3);
    m_delay = 0;

    // busy protection
    m_delay = 3;
    cfg(0, 32'h50, 32'h700, 4);
    expect_xfer(32'h50, 32'h700, 4);
    start(0);
    wr(ra(0, 2), 1); wr(ra(0, 0), 32'h3FF); start(0);
    rd(ra(0, 3), 1); rd(ra(0, 2), 4);
    wait_done(1);
    m_delay = 0;
    rd(ra(0, 0), 32'h54); rd(ra(0, 2), 4); rd(ra(0, 3), 2);

    // unmapped channel selects
    wr(ra(3, 0), 32'h123); rd(ra(3, 0), 0); rd(ra(6, 3), 0);

    // SIZE=0: completes with no bus activity
    wr(32'h70, 7);
    cfg(2, 32'h77, 32'h900, 0);
    start(2);
    wait_done(1);
    rd(ra(2, 3), 2); rd(32'h70, 4); rd(ra(2, 0), 32'h77); rd(ra(2, 1), 32'h900);

    // W1C landing in the FIN cycle of the same channel: set wins
    wr(32'h70, 7);
    rd(32'h70, 0);
    start(2);
    idle(1);
    wr(32'h70, 4);
    wait_done(1);
    rd(32'h70, 4);
    wr(32'h74, 7);
    chk("irq_fin_kept", interrupt, 1);
    wr(ra(1, 2), 0);
    start(1);
    wait_done(1);
    rd(32'h70, 6);
    int_clear = 1'b1; idle(1); int_clear = 1'b0;
    rd(32'h70, 0);
    chk("irq_int_clear", interrupt, 0);

    // reset during MWR
    wr(32'h74, 5);
    cfg(0, 32'h60, 32'h800, 2);
    m_delay = 20;
    exp_d_q.push_back(DAW'(32'h60));
    start(0);
    begin
      int n;
      n = 0;
      while (!m_cyc && n < 50) begin @(posedge clk); #1; n++; end
    end
    chk("reached_mwr", m_cyc, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("outs_after_reset", {m_cyc, d_init, m_we, m_strb, d_done, dbg_state}, 0);
    rst_n = 1'b1;
    m_delay = 0;
    idle(6);
    rd(ra(0, 0), 0); rd(ra(0, 1), 0); rd(ra(0, 2), 0); rd(ra(0, 3), 0);
    rd(32'h70, 0); rd(32'h74, 0);
    chk("irq_after_reset", interrupt, 0);
    chk("no_done_after_reset", done_cnt, exp_done);

    idle(4);
    chk("queues_empty", exp_d_q.size() + exp_m_q.size() + exp_r_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
